partition_dispatch_queue: RTL and testbench

- Upstream feeder for partition_core. Buffers partition instructions (PNEW/PSPLIT/PMERGE) in a small FIFO.
- Issues them one at a time on partition_core's op/op_valid interface and waits for op_done.
- Returns one completion record per instruction, carrying a step index, to the trace/retire logic.
- Replaces hand-sequenced op_valid pulsing with a proper valid/ready front end.

---
 rtl/partition_dispatch_queue_if.sv | 50 +++++
 rtl/partition_dispatch_queue.sv | 162 ++++++++++++++++
 tb/tb_partition_dispatch_queue.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/partition_dispatch_queue_if.sv
// Instruction, core-issue and completion signals of partition_dispatch_queue.
// slave is the dispatch queue's view; master is the surrounding logic's view.
interface partition_dispatch_queue_if #(
  parameter int REGION_WIDTH = 64,
  parameter int STEP_WIDTH   = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [7:0]              in_opcode;
  logic [7:0]              in_arg_a;
  logic [7:0]              in_arg_b;
  logic [REGION_WIDTH-1:0] in_region;

  logic [7:0]              core_op;
  logic                    core_op_valid;
  logic [REGION_WIDTH-1:0] core_pnew_region;
  logic [7:0]              core_psplit_module_id;
  logic [REGION_WIDTH-1:0] core_psplit_mask;
  logic [7:0]              core_pmerge_m1;
  logic [7:0]              core_pmerge_m2;
  logic                    core_op_done;
  logic [7:0]              core_result_module_id;

  logic                    cpl_valid;
  logic                    cpl_ready;
  logic [STEP_WIDTH-1:0]   cpl_step;
  logic [7:0]              cpl_opcode;
  logic [7:0]              cpl_result_id;
  logic                    cpl_error;

  modport slave (
    input  in_valid, in_opcode, in_arg_a, in_arg_b, in_region,
    output in_ready,
    output core_op, core_op_valid, core_pnew_region, core_psplit_module_id,
           core_psplit_mask, core_pmerge_m1, core_pmerge_m2,
    input  core_op_done, core_result_module_id,
    output cpl_valid, cpl_step, cpl_opcode, cpl_result_id, cpl_error,
    input  cpl_ready
  );

  modport master (
    output in_valid, in_opcode, in_arg_a, in_arg_b, in_region,
    input  in_ready,
    input  core_op, core_op_valid, core_pnew_region, core_psplit_module_id,
           core_psplit_mask, core_pmerge_m1, core_pmerge_m2,
    output core_op_done, core_result_module_id,
    input  cpl_valid, cpl_step, cpl_opcode, cpl_result_id, cpl_error,
    output cpl_ready
  );
endinterface

// File: rtl/partition_dispatch_queue.sv
// Instruction FIFO feeding partition_core one op at a time; issue strobe 2 cycles after accept.
// in_ready low while FIFO full; completion held until cpl_ready. PARTITION_DISPATCH_RANGECHECK_EN adds operand checks.
module partition_dispatch_queue #(
  parameter int DEPTH          = 4,
  parameter int REGION_WIDTH   = 64,
  parameter int MAX_MODULES    = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int STEP_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  partition_dispatch_queue_if.slave bus,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] MAX_ID    = 8'(MAX_MODULES);
  localparam logic [7:0] OP_PNEW   = 8'h00;
  localparam logic [7:0] OP_PSPLIT = 8'h01;
  localparam logic [7:0] OP_PMERGE = 8'h02;
`ifdef PARTITION_DISPATCH_RANGECHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]              opcode;
    logic [7:0]              arg_a;
    logic [7:0]              arg_b;
    logic [REGION_WIDTH-1:0] region;
  } instr_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMPLETE} state_t;

  instr_t                mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  state_t                state;
  logic [TW-1:0]         tmo;
  logic [STEP_WIDTH-1:0] step;
  logic                  push, pop, range_bad;
  instr_t                head;

  assign head         = mem[rd_ptr];
  assign bus.in_ready = (fifo_count != CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state == IDLE) && (fifo_count != '0);
  assign bus.cpl_step = step;
  assign busy         = (state != IDLE) || (fifo_count != '0);

  // Operand sanity of the FIFO head; only acted on when range checking is built in.
  always_comb begin
    range_bad = 1'b0;
    case (head.opcode)
      OP_PNEW:   range_bad = (head.region == '0);
      OP_PSPLIT: range_bad = (head.arg_a >= MAX_ID);
      OP_PMERGE: range_bad = (head.arg_a >= MAX_ID) || (head.arg_b >= MAX_ID) ||
                             (head.arg_a == head.arg_b);
      default:   range_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_opcode, bus.in_arg_a, bus.in_arg_b, bus.in_region};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= IDLE;
      tmo                       <= '0;
      step                      <= '0;
      bus.core_op               <= '0;
      bus.core_op_valid         <= 1'b0;
      bus.core_pnew_region      <= '0;
      bus.core_psplit_module_id <= '0;
      bus.core_psplit_mask      <= '0;
      bus.core_pmerge_m1        <= '0;
      bus.core_pmerge_m2        <= '0;
      bus.cpl_valid             <= 1'b0;
      bus.cpl_opcode            <= '0;
      bus.cpl_result_id         <= '0;
      bus.cpl_error             <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          bus.cpl_opcode <= head.opcode;
          if (head.opcode > OP_PMERGE) begin
            bus.cpl_error     <= 1'b1;
            bus.cpl_result_id <= 8'hFF;
            bus.cpl_valid     <= 1'b1;
            state             <= COMPLETE;
          end else if (RANGE_CHECK && range_bad) begin
            bus.cpl_error     <= 1'b1;
            bus.cpl_result_id <= 8'hFD;
            bus.cpl_valid     <= 1'b1;
            state             <= COMPLETE;
          end else begin
            // Only the operands of the issued opcode move; the rest keep their last values.
            bus.core_op       <= head.opcode;
            bus.core_op_valid <= 1'b1;
            case (head.opcode)
              OP_PNEW:   bus.core_pnew_region <= head.region;
              OP_PSPLIT: begin
                bus.core_psplit_module_id <= head.arg_a;
                bus.core_psplit_mask      <= head.region;
              end
              default: begin
                bus.core_pmerge_m1 <= head.arg_a;
                bus.core_pmerge_m2 <= head.arg_b;
              end
            endcase
            state <= ISSUE;
          end
        end
        ISSUE: begin
          bus.core_op_valid <= 1'b0;
          tmo               <= '0;
          state             <= WAIT;
        end
        WAIT: begin
          if (bus.core_op_done) begin
            bus.cpl_result_id <= bus.core_result_module_id;
            bus.cpl_error     <= 1'b0;
            bus.cpl_valid     <= 1'b1;
            state             <= COMPLETE;
          end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            bus.cpl_result_id <= 8'hFE;
            bus.cpl_error     <= 1'b1;
            bus.cpl_valid     <= 1'b1;
            state             <= COMPLETE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        COMPLETE: if (bus.cpl_ready) begin
          bus.cpl_valid <= 1'b0;
          step          <= step + 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_partition_dispatch_queue.sv
// Bench for partition_dispatch_queue: vector table plus hand sequences for stall, timeout, hold and reset.
module tb_partition_dispatch_queue;
  localparam int RW    = 64;
  localparam int SW    = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0]    op;
    logic [7:0]    a;
    logic [7:0]    b;
    logic [RW-1:0] region;
    bit            iss;
    logic [7:0]    res;
    bit            err;
  } vec_t;

  typedef struct {
    logic [7:0]    op;
    logic [7:0]    a;
    logic [7:0]    b;
    logic [RW-1:0] region;
  } iss_t;

  typedef struct {
    logic [7:0]    op;
    logic [7:0]    res;
    bit            err;
    logic [SW-1:0] step;
  } cpl_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    busy;

  partition_dispatch_queue_if #(.REGION_WIDTH(RW), .STEP_WIDTH(SW)) bus ();

  partition_dispatch_queue #(
    .DEPTH(DEPTH), .REGION_WIDTH(RW), .MAX_MODULES(8), .TIMEOUT_CYCLES(64), .STEP_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_miss = 0;
  iss_t          exp_iss[$];
  cpl_t          exp_cpl[$];
  logic [SW-1:0] sb_step = '0;
  bit            core_stall = 1'b0;
  vec_t          tv [11];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [RW-1:0] region, input bit iss, input logic [7:0] res,
                              input bit err);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.region = region; v.iss = iss; v.res = res; v.err = err;
    return v;
  endfunction

  function automatic logic [95:0] iss_key(input logic [7:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [RW-1:0] r);
    case (op)
      8'h00:   return {op, 24'h0, r};
      8'h01:   return {op, a, 16'h0, r};
      default: return {op, a, b, 8'h0, 64'h0};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Core model: result depends on operands, op_done two cycles after the issue strobe unless stalled.
  int         cd = 0;
  bit         pend = 1'b0;
  logic [7:0] mres = '0;
  always @(negedge clk) begin
    if (rst) begin
      bus.core_op_done          = 1'b0;
      bus.core_result_module_id = 8'h00;
      cd   = 0;
      pend = 1'b0;
    end else begin
      bus.core_op_done = 1'b0;
      if (bus.core_op_valid) begin
        cd   = 2;
        pend = 1'b0;
        case (bus.core_op)
          8'h00:   mres = 8'hA0 ^ bus.core_pnew_region[7:0];
          8'h01:   mres = 8'h40 + bus.core_psplit_module_id;
          default: mres = 8'h80 + bus.core_pmerge_m1 + bus.core_pmerge_m2;
        endcase
      end else if (cd != 0) begin
        cd--;
        if (cd == 0) pend = 1'b1;
      end
      if (pend && !core_stall) begin
        bus.core_op_done          = 1'b1;
        bus.core_result_module_id = mres;
        pend = 1'b0;
      end
    end
  end

  iss_t mi;
  cpl_t mc;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.core_op_valid) begin
        if (exp_iss.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_issue: op 0x%0h issued, no issue expected", bus.core_op);
        end else begin
          mi = exp_iss.pop_front();
          chk("issue",
              iss_key(bus.core_op,
                      (bus.core_op == 8'h01) ? bus.core_psplit_module_id : bus.core_pmerge_m1,
                      bus.core_pmerge_m2,
                      (bus.core_op == 8'h00) ? bus.core_pnew_region : bus.core_psplit_mask),
              iss_key(mi.op, mi.a, mi.b, mi.region));
        end
      end
      if (bus.cpl_valid && bus.cpl_ready) begin
        if (exp_cpl.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_cpl: step %0d op 0x%0h, no completion expected",
                   bus.cpl_step, bus.cpl_opcode);
        end else begin
          mc = exp_cpl.pop_front();
          chk("completion",
              96'({bus.cpl_opcode, bus.cpl_result_id, 7'h0, bus.cpl_error, bus.cpl_step}),
              96'({mc.op, mc.res, 7'h0, mc.err, mc.step}));
        end
      end
    end
  end

  task automatic push(input vec_t v);
    int   w = 0;
    iss_t ie;
    cpl_t ce;
    bus.in_valid  = 1'b1;
    bus.in_opcode = v.op;
    bus.in_arg_a  = v.a;
    bus.in_arg_b  = v.b;
    bus.in_region = v.region;
    while (!bus.in_ready && w < 200) begin
      tick();
      w++;
    end
    chk("push_accept", 96'(bus.in_ready), 96'(1));
    if (bus.in_ready) begin
      if (v.iss) begin
        ie.op = v.op; ie.a = v.a; ie.b = v.b; ie.region = v.region;
        exp_iss.push_back(ie);
      end
      ce.op = v.op; ce.res = v.res; ce.err = v.err; ce.step = sb_step;
      exp_cpl.push_back(ce);
      sb_step++;
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int w = 0;
    while ((exp_cpl.size() != 0 || exp_iss.size() != 0) && w < budget) begin
      tick();
      w++;
    end
    chk(name, 96'(exp_cpl.size() + exp_iss.size()), 96'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            w;
    int            k;
    logic [SW-1:0] s0;

    tv[0]  = mk(8'h00, 8'h00, 8'h00, 64'h7,    1'b1, 8'hA7, 1'b0);
    tv[1]  = mk(8'h00, 8'h00, 8'h00, 64'h30,   1'b1, 8'h90, 1'b0);
    tv[2]  = mk(8'h01, 8'h00, 8'h00, 64'h1,    1'b1, 8'h40, 1'b0);
    tv[3]  = mk(8'h02, 8'h01, 8'h02, 64'h0,    1'b1, 8'h83, 1'b0);
    tv[4]  = mk(8'h05, 8'h00, 8'h00, 64'h0,    1'b0, 8'hFF, 1'b1);
`ifdef PARTITION_DISPATCH_RANGECHECK_EN
    tv[5]  = mk(8'h02, 8'h03, 8'h03, 64'h0,    1'b0, 8'hFD, 1'b1);
    tv[6]  = mk(8'h01, 8'h08, 8'h00, 64'hF0,   1'b0, 8'hFD, 1'b1);
    tv[7]  = mk(8'h00, 8'h00, 8'h00, 64'h0,    1'b0, 8'hFD, 1'b1);
`else
    tv[5]  = mk(8'h02, 8'h03, 8'h03, 64'h0,    1'b1, 8'h86, 1'b0);
    tv[6]  = mk(8'h01, 8'h08, 8'h00, 64'hF0,   1'b1, 8'h48, 1'b0);
    tv[7]  = mk(8'h00, 8'h00, 8'h00, 64'h0,    1'b1, 8'hA0, 1'b0);
`endif
    tv[8]  = mk(8'h01, 8'h07, 8'h00, 64'hABCD, 1'b1, 8'h47, 1'b0);
    tv[9]  = mk(8'hFF, 8'h01, 8'h01, 64'h5,    1'b0, 8'hFF, 1'b1);
    tv[10] = mk(8'h02, 8'h07, 8'h06, 64'h0,    1'b1, 8'h8D, 1'b0);

    bus.in_valid  = 1'b0;
    bus.in_opcode = 8'h00;
    bus.in_arg_a  = 8'h00;
    bus.in_arg_b  = 8'h00;
    bus.in_region = '0;
    bus.cpl_ready = 1'b1;

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_in_ready",   96'(bus.in_ready), 96'(1));
    chk("rst_fifo_count", 96'(fifo_count), 96'(0));
    chk("rst_busy",       96'(busy), 96'(0));
    chk("rst_cpl", 96'({bus.cpl_valid, bus.cpl_opcode, bus.cpl_result_id, bus.cpl_error, bus.cpl_step}),
        96'(0));
    chk("rst_op_valid",   96'(bus.core_op_valid), 96'(0));

    // Issue latency: accepted at edge N, strobe during the cycle after edge N+1.
    push(mk(8'h00, 8'h00, 8'h00, 64'h5, 1'b1, 8'hA5, 1'b0));
    chk("lat_count",    96'(fifo_count), 96'(1));
    chk("lat_pre",      96'(bus.core_op_valid), 96'(0));
    tick();
    chk("lat_issue",    96'(bus.core_op_valid), 96'(1));
    tick();
    chk("lat_one_shot", 96'(bus.core_op_valid), 96'(0));
    chk("lat_busy",     96'(busy), 96'(1));
    wait_drain("lat_drain", 50);

    for (int i = 0; i < 11; i++) push(tv[i]);
    wait_drain("table_drain", 200);

    // Core stalled: the FIFO fills, in_ready drops, then everything completes in order.
    core_stall = 1'b1;
    for (int i = 0; i < 5; i++) push(mk(8'h00, 8'h00, 8'h00, 64'(32'h20 + i), 1'b1, 8'(8'h80 + i), 1'b0));
    chk("full_count",    96'(fifo_count), 96'(4));
    chk("full_in_ready", 96'(bus.in_ready), 96'(0));
    fork
      push(mk(8'h01, 8'h05, 8'h00, 64'hFF, 1'b1, 8'h45, 1'b0));
      begin
        repeat (12) tick();
        core_stall = 1'b0;
      end
    join
    wait_drain("stall_drain", 300);

    // No op_done: error completion 64 WAIT cycles later, then the next entry issues normally.
    core_stall = 1'b1;
    push(mk(8'h02, 8'h04, 8'h05, 64'h0,    1'b1, 8'hFE, 1'b1));
    push(mk(8'h01, 8'h02, 8'h00, 64'hFF00, 1'b1, 8'h42, 1'b0));
    w = 0;
    while (!bus.core_op_valid && w < 20) begin tick(); w++; end
    k = 0;
    while (!bus.cpl_valid && k < 200) begin tick(); k++; end
    chk("timeout_latency", 96'(k), 96'(65));
    core_stall = 1'b0;
    wait_drain("timeout_drain", 100);

    // Completion held: fields stay put and the queued entry is not issued.
    bus.cpl_ready = 1'b0;
    s0 = sb_step;
    push(mk(8'h00, 8'h00, 8'h00, 64'h55, 1'b1, 8'hF5, 1'b0));
    push(mk(8'h00, 8'h00, 8'h00, 64'h66, 1'b1, 8'hC6, 1'b0));
    w = 0;
    while (!bus.cpl_valid && w < 50) begin tick(); w++; end
    for (int i = 0; i < 10; i++) begin
      chk("hold_fields", 96'({bus.cpl_valid, bus.cpl_opcode, bus.cpl_result_id, bus.cpl_error, bus.cpl_step}),
          96'({1'b1, 8'h00, 8'hF5, 1'b0, s0}));
      chk("hold_no_issue", 96'(bus.core_op_valid), 96'(0));
      tick();
    end
    bus.cpl_ready = 1'b1;
    wait_drain("hold_drain", 100);

    // Reset while WAITing with another entry queued: everything is dropped.
    core_stall = 1'b1;
    push(mk(8'h00, 8'h00, 8'h00, 64'h11, 1'b1, 8'hB1, 1'b0));
    push(mk(8'h01, 8'h01, 8'h00, 64'h3,  1'b1, 8'h41, 1'b0));
    repeat (3) tick();
    rst = 1'b1;
    tick();
    exp_iss.delete();
    exp_cpl.delete();
    sb_step = '0;
    chk("mrst_fifo_count", 96'(fifo_count), 96'(0));
    chk("mrst_in_ready",   96'(bus.in_ready), 96'(1));
    chk("mrst_busy",       96'(busy), 96'(0));
    chk("mrst_cpl", 96'({bus.cpl_valid, bus.cpl_opcode, bus.cpl_result_id, bus.cpl_error, bus.cpl_step}),
        96'(0));
    chk("mrst_core_ids", 96'({bus.core_op_valid, bus.core_op, bus.core_psplit_module_id,
                              bus.core_pmerge_m1, bus.core_pmerge_m2}), 96'(0));
    chk("mrst_region",   96'(bus.core_pnew_region), 96'(0));
    chk("mrst_mask",     96'(bus.core_psplit_mask), 96'(0));
    rst = 1'b0;
    core_stall = 1'b0;
    repeat (80) tick();
    push(mk(8'h02, 8'h00, 8'h07, 64'h0, 1'b1, 8'h87, 1'b0));
    wait_drain("post_rst_drain", 50);
    chk("idle_end", 96'({busy, fifo_count}), 96'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
